// File: rtl/packet_pkg.sv
// Shared definitions for the packet framing path: header layout, packet type
// codes and the framer state encoding.
package packet_pkg;

  localparam int HDR_BYTES = 3;
  localparam int LEN_W     = 16;
  localparam int TYPE_W    = 8;
  localparam int HDR_W     = LEN_W + TYPE_W;

  localparam logic [TYPE_W-1:0] TYPE_Z = 8'd122;
  localparam logic [TYPE_W-1:0] TYPE_O = 8'd111;
  localparam logic [TYPE_W-1:0] TYPE_Q = 8'd113;
  localparam logic [TYPE_W-1:0] TYPE_A = 8'd65;
  localparam logic [TYPE_W-1:0] TYPE_B = 8'd66;
  localparam logic [TYPE_W-1:0] TYPE_D = 8'd68;

  // Largest payload whose header length (payload + 3) still fits in 16 bits.
  localparam logic [LEN_W-1:0] MAX_PAYLOAD_LEN = 16'd65532;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PASS,
    ST_FLUSH
  } framer_state_t;

endpackage

// File: rtl/framer_out_reg.sv
// Output stage with valid/ready: holds its word stable while stalled and
// reports when it can take a new word in the same cycle.
module framer_out_reg #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    sop,
  input  logic                    eop,
  input  logic [DATA_WIDTH/8-1:0] mod,
  input  logic [DATA_WIDTH-1:0]   dat,
  input  logic                    out_rdy,
  output logic                    out_val,
  output logic                    out_sop,
  output logic                    out_eop,
  output logic [DATA_WIDTH/8-1:0] out_mod,
  output logic [DATA_WIDTH-1:0]   out_dat,
  output logic                    free
);

  assign free = !out_val || out_rdy;

  // The owner only asserts load when free, so a stalled word is never overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_val <= 1'b0;
      out_sop <= 1'b0;
      out_eop <= 1'b0;
      out_mod <= '0;
      out_dat <= '0;
    end else if (load) begin
      out_val <= 1'b1;
      out_sop <= sop;
      out_eop <= eop;
      out_mod <= mod;
      out_dat <= dat;
    end else if (out_rdy) begin
      out_val <= 1'b0;
    end
  end

endmodule

// File: rtl/packet_framer.sv
// Prepends the 3-byte {len16, type8} header to each payload and re-aligns the
// payload by 3 bytes through a 24-bit carry register.
module packet_framer
  import packet_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                    Clk,
  input  logic                    Rst,
  output logic                    InBus_Rdy,
  input  logic                    InBus_Val,
  input  logic                    InBus_Sop,
  input  logic                    InBus_Eop,
  input  logic [DATA_WIDTH/8-1:0] InBus_Mod,
  input  logic [DATA_WIDTH-1:0]   InBus_Dat,
  input  logic [LEN_W-1:0]        InBus_PktLen,
  input  logic [TYPE_W-1:0]       InBus_PktType,
  input  logic                    OutBus_Rdy,
  output logic                    OutBus_Val,
  output logic                    OutBus_Sop,
  output logic                    OutBus_Eop,
  output logic [DATA_WIDTH/8-1:0] OutBus_Mod,
  output logic [DATA_WIDTH-1:0]   OutBus_Dat,
  output logic                    Error
);

  localparam int N = DATA_WIDTH / 8;
  typedef logic [N-1:0] mod_t;
  localparam logic [15:0] N_BYTES = 16'(N);

  framer_state_t        state;
  logic [HDR_W-1:0]     carry;
  logic [LEN_W-1:0]     byte_count;
  logic [LEN_W-1:0]     pkt_len;
  mod_t                 flush_mod;

  logic                 out_free;
  logic                 in_fire;
  logic                 sop_beat;
  logic                 data_beat;
  logic [15:0]          beat_bytes;
  logic [15:0]          tail_bytes;
  logic [15:0]          beat_total;
  logic                 fits;
  logic [DATA_WIDTH-1:0] dat_masked;
  logic [HDR_W-1:0]     header;

  logic                 load;
  logic                 d_sop;
  logic                 d_eop;
  mod_t                 d_mod;
  logic [DATA_WIDTH-1:0] d_dat;

  assign InBus_Rdy  = (state != ST_FLUSH) && out_free;
  assign in_fire    = InBus_Val && InBus_Rdy;
  assign sop_beat   = in_fire && InBus_Sop && (state == ST_IDLE);
  assign data_beat  = in_fire && !InBus_Sop && (state == ST_PASS);
  assign header     = {InBus_PktLen + 16'(HDR_BYTES), InBus_PktType};
  assign tail_bytes = 16'(HDR_BYTES) + beat_bytes;
  assign fits       = tail_bytes <= N_BYTES;
  assign beat_total = byte_count + beat_bytes;

  always_comb begin
    beat_bytes = N_BYTES;
    if (InBus_Eop && (InBus_Mod != '0) && (InBus_Mod < mod_t'(N)))
      beat_bytes = 16'(InBus_Mod);
  end

  // Bytes past the valid count are zeroed so padding never leaks downstream.
  always_comb begin
    dat_masked = InBus_Dat;
    for (int i = 0; i < N; i++)
      if (16'(i) >= beat_bytes)
        dat_masked[DATA_WIDTH-1-8*i -: 8] = 8'h00;
  end

  always_comb begin
    load  = 1'b0;
    d_sop = 1'b0;
    d_eop = 1'b0;
    d_mod = '0;
    d_dat = '0;
    if (sop_beat || data_beat) begin
      load  = 1'b1;
      d_sop = sop_beat;
      d_dat = {(sop_beat ? header : carry), dat_masked[DATA_WIDTH-1:HDR_W]};
      if (InBus_Eop && fits) begin
        d_eop = 1'b1;
        d_mod = (tail_bytes == N_BYTES) ? '0 : mod_t'(tail_bytes);
      end
    end else if ((state == ST_FLUSH) && out_free) begin
      load  = 1'b1;
      d_eop = 1'b1;
      d_mod = flush_mod;
      d_dat = {carry, {(DATA_WIDTH-HDR_W){1'b0}}};
    end
  end

  framer_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk     (Clk),
    .rst     (Rst),
    .load    (load),
    .sop     (d_sop),
    .eop     (d_eop),
    .mod     (d_mod),
    .dat     (d_dat),
    .out_rdy (OutBus_Rdy),
    .out_val (OutBus_Val),
    .out_sop (OutBus_Sop),
    .out_eop (OutBus_Eop),
    .out_mod (OutBus_Mod),
    .out_dat (OutBus_Dat),
    .free    (out_free)
  );

  // Error is registered, so every cause shows up the cycle after the offending accept.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= ST_IDLE;
      carry      <= '0;
      byte_count <= '0;
      pkt_len    <= '0;
      flush_mod  <= '0;
      Error      <= 1'b0;
    end else begin
      Error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_fire) begin
            if (InBus_Sop) begin
              carry      <= dat_masked[HDR_W-1:0];
              pkt_len    <= InBus_PktLen;
              byte_count <= beat_bytes;
              if ((InBus_PktLen > MAX_PAYLOAD_LEN) ||
                  (InBus_Eop && (beat_bytes != InBus_PktLen)))
                Error <= 1'b1;
              if (!InBus_Eop) begin
                state <= ST_PASS;
              end else if (!fits) begin
                state     <= ST_FLUSH;
                flush_mod <= mod_t'(tail_bytes - N_BYTES);
              end
            end else begin
              Error <= 1'b1;
            end
          end
        end
        ST_PASS: begin
          if (in_fire) begin
            if (InBus_Sop) begin
              Error <= 1'b1;
            end else begin
              carry      <= dat_masked[HDR_W-1:0];
              byte_count <= beat_total;
              if (InBus_Eop) begin
                if (beat_total != pkt_len)
                  Error <= 1'b1;
                if (fits) begin
                  state <= ST_IDLE;
                end else begin
                  state     <= ST_FLUSH;
                  flush_mod <= mod_t'(tail_bytes - N_BYTES);
                end
              end
            end
          end
        end
        ST_FLUSH: begin
          if (out_free)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_framer.sv
// Self-checking bench for packet_framer: table vectors, hand-written corner
// sequences and randomized packets checked against a byte-stream model.
module tb_packet_framer;
  import packet_pkg::*;

  localparam int DW = 64;
  localparam int N  = DW / 8;
  typedef logic [N-1:0] mod_t;

  typedef struct packed {
    logic            sop;
    logic            eop;
    logic [N-1:0]    mod;
    logic [DW-1:0]   dat;
  } word_t;

  typedef struct {
    string        name;
    int           len;
    logic [7:0]   typ;
    int           nbytes;
    int           exp_words;
    int           exp_last_mod;
    logic [23:0]  exp_hdr;
    bit           exp_err;
    int           exp_rdy_low;
  } vec_t;

  logic          Clk;
  logic          Rst;
  logic          InBus_Rdy;
  logic          InBus_Val;
  logic          InBus_Sop;
  logic          InBus_Eop;
  logic [N-1:0]  InBus_Mod;
  logic [DW-1:0] InBus_Dat;
  logic [15:0]   InBus_PktLen;
  logic [7:0]    InBus_PktType;
  logic          OutBus_Rdy;
  logic          OutBus_Val;
  logic          OutBus_Sop;
  logic          OutBus_Eop;
  logic [N-1:0]  OutBus_Mod;
  logic [DW-1:0] OutBus_Dat;
  logic          Error;

  logic          s32_in_rdy;
  logic          s32_in_val;
  logic          s32_in_sop;
  logic          s32_in_eop;
  logic [3:0]    s32_in_mod;
  logic [31:0]   s32_in_dat;
  logic [15:0]   s32_in_len;
  logic [7:0]    s32_in_type;
  logic          s32_out_val;
  logic          s32_out_sop;
  logic          s32_out_eop;
  logic [3:0]    s32_out_mod;
  logic [31:0]   s32_out_dat;
  logic          s32_error;

  int n_cmp = 0;
  int n_fail = 0;
  int err_count = 0;
  int rdy_low = 0;
  int got_base, err_base, rdy_base;
  bit bp_en = 0;
  bit rdy_force = 1;

  word_t      got_q[$];
  word_t      exp_q[$];
  logic [7:0] pay_q[$];

  packet_framer #(.DATA_WIDTH(DW)) dut (
    .Clk(Clk), .Rst(Rst),
    .InBus_Rdy(InBus_Rdy), .InBus_Val(InBus_Val), .InBus_Sop(InBus_Sop),
    .InBus_Eop(InBus_Eop), .InBus_Mod(InBus_Mod), .InBus_Dat(InBus_Dat),
    .InBus_PktLen(InBus_PktLen), .InBus_PktType(InBus_PktType),
    .OutBus_Rdy(OutBus_Rdy), .OutBus_Val(OutBus_Val), .OutBus_Sop(OutBus_Sop),
    .OutBus_Eop(OutBus_Eop), .OutBus_Mod(OutBus_Mod), .OutBus_Dat(OutBus_Dat),
    .Error(Error)
  );

  packet_framer #(.DATA_WIDTH(32)) dut32 (
    .Clk(Clk), .Rst(Rst),
    .InBus_Rdy(s32_in_rdy), .InBus_Val(s32_in_val), .InBus_Sop(s32_in_sop),
    .InBus_Eop(s32_in_eop), .InBus_Mod(s32_in_mod), .InBus_Dat(s32_in_dat),
    .InBus_PktLen(s32_in_len), .InBus_PktType(s32_in_type),
    .OutBus_Rdy(1'b1), .OutBus_Val(s32_out_val), .OutBus_Sop(s32_out_sop),
    .OutBus_Eop(s32_out_eop), .OutBus_Mod(s32_out_mod), .OutBus_Dat(s32_out_dat),
    .Error(s32_error)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    OutBus_Rdy = 1'b1;
    forever begin
      @(posedge Clk);
      #2;
      OutBus_Rdy = bp_en ? ($urandom_range(0, 99) < 70) : rdy_force;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected end before 500000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic word_t cur_word();
    return {OutBus_Sop, OutBus_Eop, OutBus_Mod, OutBus_Dat};
  endfunction

  always @(negedge Clk) begin
    if (!Rst) begin
      if (OutBus_Val && OutBus_Rdy) got_q.push_back(cur_word());
      if (Error) err_count++;
      if (!InBus_Rdy) rdy_low++;
    end
  end

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected output words: the header bytes followed by the payload, cut into N-byte words.
  task automatic build_expected(input int len, input logic [7:0] typ);
    logic [7:0]  s[$];
    logic [15:0] hl;
    int          total, nw;
    word_t       w;
    exp_q.delete();
    hl = 16'(len + 3);
    s.push_back(hl[15:8]);
    s.push_back(hl[7:0]);
    s.push_back(typ);
    foreach (pay_q[i]) s.push_back(pay_q[i]);
    total = s.size();
    nw = (total + N - 1) / N;
    for (int k = 0; k < nw; k++) begin
      w = '0;
      for (int i = 0; i < N; i++)
        if (k * N + i < total) w.dat[DW-1-8*i -: 8] = s[k*N+i];
      w.sop = (k == 0);
      w.eop = (k == nw - 1);
      w.mod = (k == nw - 1) ? mod_t'(total % N) : '0;
      exp_q.push_back(w);
    end
  endtask

  task automatic wait_accept(input string tag);
    bit done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge Clk);
      if (InBus_Rdy) done = 1;
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL %s: got no InBus_Rdy, expected accept within 200 cycles", tag);
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_stimulus(input int len, input logic [7:0] typ, input int nbytes, input bit stall);
    int            nbeats;
    logic [DW-1:0] d;
    word_t         snap;
    bit            drained;
    @(posedge Clk);
    #1;
    pay_q.delete();
    for (int i = 0; i < nbytes; i++) pay_q.push_back(8'($urandom_range(0, 255)));
    build_expected(len, typ);
    got_base = got_q.size();
    err_base = err_count;
    rdy_base = rdy_low;
    nbeats = (nbytes + N - 1) / N;
    for (int k = 0; k < nbeats; k++) begin
      d = {$urandom, $urandom};
      for (int i = 0; i < N; i++)
        if (k * N + i < nbytes) d[DW-1-8*i -: 8] = pay_q[k*N+i];
      InBus_Val     = 1'b1;
      InBus_Sop     = (k == 0);
      InBus_Eop     = (k == nbeats - 1);
      InBus_Mod     = (k == nbeats - 1) ? mod_t'(nbytes % N) : '0;
      InBus_Dat     = d;
      InBus_PktLen  = 16'(len);
      InBus_PktType = typ;
      if (stall && k == 2) begin
        rdy_force = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge Clk);
          if (c == 0) snap = cur_word();
          check_val("stall in_rdy", InBus_Rdy, 0);
          check_val("stall out_val", OutBus_Val, 1);
          if (c > 0) check_val("stall hold", cur_word(), snap);
        end
        rdy_force = 1'b1;
      end
      wait_accept("beat");
    end
    InBus_Val = 1'b0;
    InBus_Sop = 1'b0;
    InBus_Eop = 1'b0;
    drained = 0;
    for (int c = 0; c < 400 && !drained; c++) begin
      @(negedge Clk);
      if (got_q.size() - got_base >= exp_q.size()) drained = 1;
    end
    if (!drained) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL drain: got %0d words, expected %0d within 400 cycles",
               got_q.size() - got_base, exp_q.size());
    end
    repeat (4) @(negedge Clk);
  endtask

  task automatic check_output(input string tag, input bit exp_err);
    int ng;
    ng = got_q.size() - got_base;
    check_val({tag, " words"}, ng, exp_q.size());
    for (int i = 0; i < ng && i < exp_q.size(); i++) begin
      check_val($sformatf("%s w%0d dat", tag, i), got_q[got_base+i].dat, exp_q[i].dat);
      check_val($sformatf("%s w%0d sop/eop/mod", tag, i),
                {got_q[got_base+i].sop, got_q[got_base+i].eop, got_q[got_base+i].mod},
                {exp_q[i].sop, exp_q[i].eop, exp_q[i].mod});
    end
    check_val({tag, " error"}, (err_count - err_base) > 0, exp_err);
  endtask

  initial begin
    vec_t vecs[6];
    int   ng, nb, len;

    vecs[0] = '{"len33",    33,    TYPE_Z, 33, 5, 4, 24'h00247A, 1'b0, 0};
    vecs[1] = '{"len28",    28,    TYPE_Z, 28, 4, 7, 24'h001F7A, 1'b0, 0};
    vecs[2] = '{"len16",    16,    TYPE_Z, 16, 3, 3, 24'h00137A, 1'b0, 1};
    vecs[3] = '{"len5",     5,     TYPE_Z, 5,  1, 0, 24'h00087A, 1'b0, 0};
    vecs[4] = '{"len20b24", 20,    TYPE_O, 24, 4, 3, 24'h00176F, 1'b1, 1};
    vecs[5] = '{"ovf",      65533, TYPE_Q, 5,  1, 0, 24'h000071, 1'b1, 0};

    Rst = 1'b1;
    InBus_Val = 0; InBus_Sop = 0; InBus_Eop = 0; InBus_Mod = '0; InBus_Dat = '0;
    InBus_PktLen = '0; InBus_PktType = '0;
    s32_in_val = 0; s32_in_sop = 0; s32_in_eop = 0; s32_in_mod = '0; s32_in_dat = '0;
    s32_in_len = '0; s32_in_type = '0;
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b0;

    @(negedge Clk);
    check_val("reset out_val", OutBus_Val, 0);
    check_val("reset out_word", cur_word(), 0);
    check_val("reset error", Error, 0);
    check_val("reset in_rdy", InBus_Rdy, 1);
    check_val("reset32 out_val", s32_out_val, 0);

    $display("[TB] table vectors");
    foreach (vecs[v]) begin
      apply_stimulus(vecs[v].len, vecs[v].typ, vecs[v].nbytes, 0);
      check_output(vecs[v].name, vecs[v].exp_err);
      ng = got_q.size() - got_base;
      check_val({vecs[v].name, " nwords"}, ng, vecs[v].exp_words);
      if (ng > 0) begin
        check_val({vecs[v].name, " header"}, got_q[got_base].dat[DW-1:DW-24], vecs[v].exp_hdr);
        check_val({vecs[v].name, " last mod"}, got_q[got_base+ng-1].mod, vecs[v].exp_last_mod);
      end
      check_val({vecs[v].name, " rdy low cycles"}, rdy_low - rdy_base, vecs[v].exp_rdy_low);
    end

    $display("[TB] stall sequence");
    apply_stimulus(33, TYPE_Z, 33, 1);
    check_output("stall33", 1'b0);

    $display("[TB] non-Sop beat in IDLE");
    @(posedge Clk);
    #1;
    got_base = got_q.size();
    err_base = err_count;
    InBus_Val = 1'b1; InBus_Sop = 1'b0; InBus_Eop = 1'b1; InBus_Mod = 8'd4;
    InBus_Dat = {$urandom, $urandom};
    wait_accept("idle nonsop");
    InBus_Val = 1'b0; InBus_Eop = 1'b0;
    repeat (4) @(negedge Clk);
    check_val("idle nonsop words", got_q.size() - got_base, 0);
    check_val("idle nonsop error pulses", err_count - err_base, 1);

    $display("[TB] 32-bit single beat");
    @(posedge Clk);
    #1;
    s32_in_val = 1; s32_in_sop = 1; s32_in_eop = 1; s32_in_mod = 4'd1;
    s32_in_dat = 32'hABCDEF12; s32_in_len = 16'd1; s32_in_type = TYPE_Z;
    @(negedge Clk);
    check_val("dw32 in_rdy", s32_in_rdy, 1);
    @(posedge Clk);
    #1 s32_in_val = 0; s32_in_sop = 0; s32_in_eop = 0;
    @(negedge Clk);
    check_val("dw32 out_val", s32_out_val, 1);
    check_val("dw32 sop/eop/mod", {s32_out_sop, s32_out_eop, s32_out_mod}, {1'b1, 1'b1, 4'd0});
    check_val("dw32 dat", s32_out_dat, 32'h00047AAB);
    check_val("dw32 error", s32_error, 0);

    $display("[TB] reset mid-packet");
    @(posedge Clk);
    #1;
    InBus_Val = 1'b1; InBus_Sop = 1'b1; InBus_Eop = 1'b0; InBus_Mod = '0;
    InBus_Dat = {$urandom, $urandom}; InBus_PktLen = 16'd33; InBus_PktType = TYPE_A;
    wait_accept("rst b0");
    InBus_Sop = 1'b0;
    InBus_Dat = {$urandom, $urandom};
    wait_accept("rst b1");
    #2 Rst = 1'b1;
    #1;
    check_val("midrst out_val", OutBus_Val, 0);
    check_val("midrst out_word", cur_word(), 0);
    check_val("midrst error", Error, 0);
    InBus_Val = 1'b0;
    @(posedge Clk);
    #1 Rst = 1'b0;
    apply_stimulus(12, TYPE_B, 12, 0);
    check_output("post reset", 1'b0);

    $display("[TB] random packets with backpressure");
    bp_en = 1'b1;
    for (int p = 0; p < 30; p++) begin
      nb = $urandom_range(1, 40);
      len = nb;
      if ($urandom_range(0, 3) == 0) len = nb + $urandom_range(1, 6);
      apply_stimulus(len, 8'($urandom_range(0, 255)), nb, 0);
      check_output($sformatf("rnd%0d", p), len != nb);
    end
    bp_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/packet_framer.md
Name: packet_framer

Overview:
- Upstream neighbour of packet_chopper. Takes raw sub-packet payloads with sideband length and type, and emits InBus-format packets.
- On every packet it prepends the 3-byte header {len16 = payload+3, type8}. The header occupies the top 24 bits of the first output word.
- Because of the header, the payload is re-aligned by 3 bytes. Backpressure is ready/valid on both sides.
- Output connects directly to packet_chopper InBus_* with matching DATA_WIDTH.

Parameters:
- DATA_WIDTH, 64: bus width in bits, a multiple of 8, minimum 32. Byte order is big-endian, MSB byte first.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  reset, asynchronous, active-high.
- InBus_Rdy  out  1  framer can accept an input beat.
- InBus_Val  in  1  input beat valid.
- InBus_Sop  in  1  first beat of payload.
- InBus_Eop  in  1  last beat of payload.
- InBus_Mod  in  DATA_WIDTH/8  valid bytes in the Eop beat; 0 means all DATA_WIDTH/8 bytes are valid.
- InBus_Dat  in  DATA_WIDTH  payload data.
- InBus_PktLen  in  16  payload byte count; sampled on the Sop beat.
- InBus_PktType  in  8  packet type; sampled on the Sop beat.
- OutBus_Rdy  in  1  downstream accepts.
- OutBus_Val  out  1  output beat valid.
- OutBus_Sop  out  1  first output beat.
- OutBus_Eop  out  1  last output beat.
- OutBus_Mod  out  DATA_WIDTH/8  valid bytes in the last output beat; 0 means full.
- OutBus_Dat  out  DATA_WIDTH  framed data.
- Error  out  1  one-cycle protocol/length error pulse.

Behaviour:
- Let N = DATA_WIDTH/8.
- Handshakes:
  - An input transfer occurs when InBus_Val & InBus_Rdy.
  - An output transfer occurs when OutBus_Val & OutBus_Rdy.
  - InBus_Rdy = (state != FLUSH) & (!OutBus_Val | OutBus_Rdy). This combinational path from OutBus_Rdy is intentional.
- Output register: OutBus_* are registered, giving 1-cycle latency from input accept to OutBus_Val.
  - While OutBus_Val=1 and OutBus_Rdy=0, all OutBus_* hold stable.
- Carry register (24 bits):
  - Each accepted beat produces OutBus_Dat = {carry, InBus_Dat[DW-1:24]}.
  - The carry is then updated to InBus_Dat[23:0].
  - On a Sop beat, the carry used is the header {InBus_PktLen+3 (16-bit wrap), InBus_PktType}, not the stored value.
- States:
  - IDLE: waiting for Sop.
    - Sop beat → PASS, or stays IDLE if the beat also has Eop and fits in one word.
    - A non-Sop beat is accepted, dropped, and pulses Error.
  - PASS: non-Sop beats are forwarded.
    - A Sop beat in PASS pulses Error and is dropped.
    - On the Eop beat, let m = (InBus_Mod==0 ? N : InBus_Mod) and t = 3+m.
      - t ≤ N: emit with OutBus_Eop=1 and OutBus_Mod = (t==N ? 0 : t); → IDLE.
      - t > N: emit a full word with Eop=0; → FLUSH.
  - FLUSH: InBus_Rdy=0.
    - When the output register frees, emit {carry, zeros} with Eop=1 and Mod = t−N.
    - Then → IDLE.
- OutBus_Sop=1 only on the word built from the Sop beat. Unused trailing bytes are zero.
- Byte counter (16-bit):
  - Loaded with m (or N) on Sop and accumulated per beat.
  - If the count at Eop ≠ captured PktLen, Error pulses on the cycle after the Eop accept. The packet is still forwarded unchanged.
- Header overflow: if InBus_PktLen > 65532, Error pulses at Sop accept and the header length wraps.
- Reset values: OutBus_Val/Sop/Eop = 0, OutBus_Mod = 0, OutBus_Dat = 0, Error = 0, state IDLE, counters 0.
  - InBus_Rdy = 1 once Rst deasserts.
  - Reset mid-packet discards all partial state; no Eop is emitted for the truncated packet.
- Simultaneous events: a FLUSH word and the next packet's Sop cannot overlap, because InBus_Rdy=0 during FLUSH.

Decomposition:
- Shared package packet_pkg: HDR_BYTES=3, the header field widths (LEN 16, TYPE 8), the type constants ('z'=122, 'o'=111, 'q'=113, 'A','B','D'), and the state encoding.
- One sub-module, framer_out_reg: a stall-holding output register with Val/Rdy, reused for the flush word.

Test Plan (DATA_WIDTH=64 unless noted):
- PktLen 33, type 122, 5 beats with last Mod 1 → 5 output words.
  - Word0 [63:40] = 0x00247A.
  - Last word Eop with Mod 4.
  - Error=0.
- PktLen 28, type 122, 4 beats with last Mod 4 → 4 output words.
  - Header 0x001F7A.
  - Last Mod 7.
- PktLen 16, 2 beats with last Mod 0 → 3 output words.
  - Header len 0x0013.
  - Flush word Mod 3.
  - InBus_Rdy=0 for exactly the FLUSH cycle.
- PktLen 5, single Sop+Eop beat, Mod 5 → one word Sop=Eop=1, Mod 0, header 0x0008.
  - Repeat with DATA_WIDTH=32, PktLen 1: one word, Mod 0.
- PktLen 33 stream with OutBus_Rdy held low 3 cycles mid-packet → OutBus_* stable and InBus_Rdy=0 while stalled.
  - Output bytes match the no-stall run exactly.
- Length and protocol errors:
  - PktLen 20 but 24 bytes sent → Error one cycle after Eop; packet forwarded.
  - Non-Sop beat while IDLE → dropped, Error pulse.
  - Rst asserted mid-packet → all outputs 0 immediately; the next packet frames correctly.
